peripheral_noc_router_output_credit: RTL and testbench

Credit-based output stage of a NoC router port; successor to the ready/valid output stage.
- Per virtual channel: a packet-atomic round-robin mux over all router inputs, followed by a FIFO.
- A VC arbiter drives one physical link. Send permission comes from per-VC credit counters fed by downstream credit returns instead of a ready signal.
- VC interleaving on the link is selectable: per packet or per flit.

---
 rtl/peripheral_noc_router_pkg.sv | 18 +
 rtl/peripheral_noc_router_output_vc.sv | 90 +++++++++
 rtl/peripheral_noc_router_output_credit.sv | 121 ++++++++++++
 tb/tb_peripheral_noc_router_output_credit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_noc_router_pkg.sv
// Shared types and width helpers for the credit-based NoC router output stage.
package peripheral_noc_router_pkg;

   typedef enum logic { ARB_PACKET = 1'b0, ARB_FLIT = 1'b1 } vc_arb_mode_e;

   typedef enum logic { VC_OPEN = 1'b0, VC_HELD = 1'b1 } vc_state_e;

   // Index width for n entries; never zero so single-entry configs still get a 1-bit select.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter width able to hold 0..max_val inclusive (FIFO occupancy, credit).
   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/peripheral_noc_router_output_vc.sv
// Per-VC input stage: packet-atomic round-robin mux over the router inputs feeding a flit FIFO.
module peripheral_noc_router_output_vc
   import peripheral_noc_router_pkg::*;
#(
   parameter int FLIT_WIDTH   = 32,
   parameter int INPUTS       = 7,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
   input  logic [INPUTS-1:0]                 in_last,
   input  logic [INPUTS-1:0]                 in_valid,
   output logic [INPUTS-1:0]                 in_ready,
   input  logic                              pop,
   output logic                              head_valid,
   output logic [FLIT_WIDTH-1:0]             head_flit,
   output logic                              head_last
);

   localparam int IW = cw(INPUTS);
   localparam int PW = cw(BUFFER_DEPTH);
   localparam int CW = cnt_w(BUFFER_DEPTH);

   logic [IW-1:0]     rr_ptr, lock_idx, sel, idx;
   logic              locked, sel_found, can_push, push;
   logic [FLIT_WIDTH:0] mem [BUFFER_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;

   always_comb begin
      sel       = lock_idx;
      sel_found = locked;
      idx       = '0;
      if (!locked) begin
         for (int k = 0; k < INPUTS; k++) begin
            idx = IW'((int'(rr_ptr) + k) % INPUTS);
            if (!sel_found && in_valid[idx]) begin
               sel_found = 1'b1;
               sel       = idx;
            end
         end
      end
   end

   // A pop frees the slot in the same cycle, so a full FIFO can still accept; nothing enters during reset.
   assign can_push = rst && ((count != CW'(BUFFER_DEPTH)) || pop);

   always_comb begin
      in_ready = '0;
      if (sel_found && can_push) in_ready[sel] = 1'b1;
   end

   assign push       = in_valid[sel] && in_ready[sel];
   assign head_valid = (count != '0);
   assign {head_last, head_flit} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_last[sel], in_flit[sel]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr   <= '0;
         lock_idx <= '0;
         locked   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (in_last[sel]) begin
               locked <= 1'b0;
               rr_ptr <= (sel == IW'(INPUTS - 1)) ? '0 : sel + 1'b1;
            end else begin
               locked   <= 1'b1;
               lock_idx <= sel;
            end
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/peripheral_noc_router_output_credit.sv
// Credit-based router output port: per-VC input stages, a VC arbiter onto one link, per-VC credit counters.
//   state   | meaning
//   VC_OPEN | no VC owns the link; round robin among eligible VCs each cycle
//   VC_HELD | packet mode only: lock_vc owns the link until its last flit is sent
module peripheral_noc_router_output_credit
   import peripheral_noc_router_pkg::*;
#(
   parameter int FLIT_WIDTH   = 32,
   parameter int VCHANNELS    = 7,
   parameter int INPUTS       = 7,
   parameter int BUFFER_DEPTH = 4,
   parameter int CREDITS      = 4,
   parameter int VC_ARB_MODE  = 0
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic [VCHANNELS-1:0][INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
   input  logic [VCHANNELS-1:0][INPUTS-1:0]                 in_last,
   input  logic [VCHANNELS-1:0][INPUTS-1:0]                 in_valid,
   output logic [VCHANNELS-1:0][INPUTS-1:0]                 in_ready,
   output logic [FLIT_WIDTH-1:0]                            out_flit,
   output logic                                             out_last,
   output logic [VCHANNELS-1:0]                             out_valid,
   input  logic [VCHANNELS-1:0]                             out_credit
);

   localparam int VW = cw(VCHANNELS);
   localparam int KW = cnt_w(CREDITS);
   localparam bit FLIT_MODE = (VC_ARB_MODE == int'(ARB_FLIT));

   vc_state_e            state, state_nxt;
   logic [VW-1:0]        lock_vc, vc_ptr, win, cand;
   logic                 send;
   logic [VCHANNELS-1:0] head_valid, head_last, pop, eligible;
   logic [FLIT_WIDTH-1:0] head_flit [VCHANNELS];
   logic [KW-1:0]        credit [VCHANNELS];

   for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
      peripheral_noc_router_output_vc #(
         .FLIT_WIDTH  (FLIT_WIDTH),
         .INPUTS      (INPUTS),
         .BUFFER_DEPTH(BUFFER_DEPTH)
      ) u_vc (
         .clk       (clk),
         .rst       (rst),
         .in_flit   (in_flit[v]),
         .in_last   (in_last[v]),
         .in_valid  (in_valid[v]),
         .in_ready  (in_ready[v]),
         .pop       (pop[v]),
         .head_valid(head_valid[v]),
         .head_flit (head_flit[v]),
         .head_last (head_last[v])
      );
   end

   always_comb begin
      for (int v = 0; v < VCHANNELS; v++) begin
         eligible[v] = head_valid[v] && (credit[v] != '0);
         pop[v]      = send && (win == VW'(v));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= VC_OPEN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (FLIT_MODE)  state_nxt = VC_OPEN;
      else if (send)  state_nxt = head_last[win] ? VC_OPEN : VC_HELD;
   end

   // A held VC that runs out of credits or flits blocks the link rather than yielding it.
   always_comb begin
      send = 1'b0;
      win  = lock_vc;
      cand = '0;
      if (state == VC_HELD) begin
         send = eligible[lock_vc];
      end else begin
         for (int k = 0; k < VCHANNELS; k++) begin
            cand = VW'((int'(vc_ptr) + k) % VCHANNELS);
            if (!send && eligible[cand]) begin
               send = 1'b1;
               win  = cand;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lock_vc   <= '0;
         vc_ptr    <= '0;
         out_valid <= '0;
         out_flit  <= '0;
         out_last  <= 1'b0;
         for (int v = 0; v < VCHANNELS; v++) credit[v] <= KW'(CREDITS);
      end else begin
         out_valid <= '0;
         if (send) begin
            lock_vc   <= win;
            out_valid <= VCHANNELS'(1) << win;
            out_flit  <= head_flit[win];
            out_last  <= head_last[win];
            if (FLIT_MODE || head_last[win])
               vc_ptr <= (win == VW'(VCHANNELS - 1)) ? '0 : win + 1'b1;
         end
         // Return at full credit with no send is a downstream protocol error; saturate.
         for (int v = 0; v < VCHANNELS; v++) begin
            if (pop[v] && !out_credit[v])
               credit[v] <= credit[v] - 1'b1;
            else if (out_credit[v] && !pop[v] && (credit[v] != KW'(CREDITS)))
               credit[v] <= credit[v] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_peripheral_noc_router_output_credit.sv
// Directed bench for the credit-based router output stage across packet/flit arbitration and credit sizes.
module tb_peripheral_noc_router_output_credit;

   localparam int FW = 32;
   localparam int VC = 7;
   localparam int NI = 7;

   logic clk = 1'b0;
   logic rst;
   logic [VC-1:0][NI-1:0][FW-1:0] in_flit;
   logic [VC-1:0][NI-1:0] in_last, in_valid;
   logic [VC-1:0] out_credit;

   logic [VC-1:0][NI-1:0] rdy_a, rdy_b, rdy_c, m_ready;
   logic [FW-1:0] flit_a, flit_b, flit_c, m_flit;
   logic last_a, last_b, last_c, m_last;
   logic [VC-1:0] val_a, val_b, val_c, m_valid;
   int dsel;

   int passed, total;

   int src_vc [4], src_in [4], src_len [4], src_pos [4];
   logic [FW-1:0] src_data [4][8];
   int acc_cyc [4][8];
   logic [VC-1:0] cred_sched [64];
   logic [VC-1:0][NI-1:0] rdy_log [64];
   int log_n;
   logic [VC-1:0] log_vc [64];
   logic [FW-1:0] log_flit [64];
   logic log_last [64];
   int log_cyc [64];

   always #5 clk = ~clk;

   peripheral_noc_router_output_credit #(.FLIT_WIDTH(FW), .VCHANNELS(VC), .INPUTS(NI),
      .BUFFER_DEPTH(4), .CREDITS(4), .VC_ARB_MODE(0)) dut_a (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
      .in_ready(rdy_a), .out_flit(flit_a), .out_last(last_a), .out_valid(val_a), .out_credit(out_credit));

   peripheral_noc_router_output_credit #(.FLIT_WIDTH(FW), .VCHANNELS(VC), .INPUTS(NI),
      .BUFFER_DEPTH(4), .CREDITS(2), .VC_ARB_MODE(0)) dut_b (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
      .in_ready(rdy_b), .out_flit(flit_b), .out_last(last_b), .out_valid(val_b), .out_credit(out_credit));

   peripheral_noc_router_output_credit #(.FLIT_WIDTH(FW), .VCHANNELS(VC), .INPUTS(NI),
      .BUFFER_DEPTH(4), .CREDITS(4), .VC_ARB_MODE(1)) dut_c (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
      .in_ready(rdy_c), .out_flit(flit_c), .out_last(last_c), .out_valid(val_c), .out_credit(out_credit));

   always_comb begin
      m_ready = rdy_a; m_flit = flit_a; m_last = last_a; m_valid = val_a;
      if (dsel == 1) begin
         m_ready = rdy_b; m_flit = flit_b; m_last = last_b; m_valid = val_b;
      end else if (dsel == 2) begin
         m_ready = rdy_c; m_flit = flit_c; m_last = last_c; m_valid = val_c;
      end
   end

   task automatic apply_reset();
      rst = 1'b0;
      in_valid = '0; in_flit = '0; in_last = '0; out_credit = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic clear_stim();
      for (int s = 0; s < 4; s++) begin
         src_len[s] = 0; src_pos[s] = 0; src_vc[s] = 0; src_in[s] = 0;
         for (int k = 0; k < 8; k++) begin
            src_data[s][k] = '0; acc_cyc[s][k] = -1;
         end
      end
      for (int c = 0; c < 64; c++) begin
         cred_sched[c] = '0; rdy_log[c] = '0;
         log_vc[c] = '0; log_flit[c] = '0; log_last[c] = 1'b0; log_cyc[c] = -1;
      end
      log_n = 0;
   endtask

   task automatic add_src(input int s, input int vc, input int inp, input int base, input int len);
      src_vc[s] = vc; src_in[s] = inp; src_len[s] = len; src_pos[s] = 0;
      for (int k = 0; k < len; k++) src_data[s][k] = FW'(base + k);
   endtask

   // One iteration per cycle: drive at posedge+1, sample ready at +2, sample registered outputs after the edge.
   task automatic run(input int ncyc);
      bit acc [4];
      for (int c = 0; c < ncyc && c < 64; c++) begin
         in_valid = '0; in_flit = '0; in_last = '0;
         out_credit = cred_sched[c];
         for (int s = 0; s < 4; s++) begin
            if (src_pos[s] < src_len[s]) begin
               in_valid[src_vc[s]][src_in[s]] = 1'b1;
               in_flit[src_vc[s]][src_in[s]]  = src_data[s][src_pos[s]];
               in_last[src_vc[s]][src_in[s]]  = (src_pos[s] == src_len[s] - 1);
            end
         end
         #1;
         rdy_log[c] = m_ready;
         for (int s = 0; s < 4; s++) begin
            acc[s] = (src_pos[s] < src_len[s]) && m_ready[src_vc[s]][src_in[s]];
            if (acc[s]) acc_cyc[s][src_pos[s]] = c;
         end
         @(posedge clk);
         for (int s = 0; s < 4; s++) if (acc[s]) src_pos[s]++;
         #1;
         if (m_valid != '0 && log_n < 64) begin
            log_vc[log_n] = m_valid; log_flit[log_n] = m_flit;
            log_last[log_n] = m_last; log_cyc[log_n] = c;
            log_n++;
         end
      end
      in_valid = '0; in_last = '0; out_credit = '0;
   endtask

   task automatic test_reset();
      dsel = 0;
      rst = 1'b0;
      in_valid = '1; in_last = '1; in_flit = '1; out_credit = '1;
      @(posedge clk);
      #1;
      total++; if (val_a !== '0) $display("FAIL reset_out_valid: got %b want 0", val_a); else passed++;
      total++; if (flit_a !== '0) $display("FAIL reset_out_flit: got %h want 0", flit_a); else passed++;
      total++; if (last_a !== 1'b0) $display("FAIL reset_out_last: got %b want 0", last_a); else passed++;
      total++; if (rdy_a !== '0) $display("FAIL reset_in_ready: got %h want 0", rdy_a); else passed++;
      apply_reset();
   endtask

   task automatic test_single_packet();
      dsel = 0;
      apply_reset();
      clear_stim();
      add_src(0, 0, 2, 'hA, 3);
      run(8);
      total++; if (rdy_log[0] !== ((VC*NI)'(1) << 2))
         $display("FAIL single_grant_ready: got %h want only vc0/in2", rdy_log[0]); else passed++;
      total++; if (acc_cyc[0][0] !== 0) $display("FAIL single_accept_cycle: got %0d want 0", acc_cyc[0][0]); else passed++;
      total++; if (log_n !== 3) $display("FAIL single_count: got %0d want 3", log_n); else passed++;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (log_vc[k] !== 7'b0000001 || log_flit[k] !== FW'('hA + k) || log_last[k] !== (k == 2) || log_cyc[k] !== k + 1)
            $display("FAIL single_flit%0d: got vc=%b flit=%h last=%b cyc=%0d want vc=0000001 flit=%h last=%0d cyc=%0d",
                     k, log_vc[k], log_flit[k], log_last[k], log_cyc[k], 'hA + k, k == 2, k + 1);
         else passed++;
      end
      total++; if (val_a !== '0 || flit_a !== FW'('hC) || last_a !== 1'b1)
         $display("FAIL single_idle_hold: got valid=%b flit=%h last=%b want 0/c/1", val_a, flit_a, last_a); else passed++;
      // One credit left on VC0: only the first flit of a new 2-flit packet may go.
      clear_stim();
      add_src(0, 0, 2, 'hD, 2);
      run(8);
      total++; if (log_n !== 1 || log_flit[0] !== FW'('hD))
         $display("FAIL single_credit_left: got n=%0d flit=%h want n=1 flit=d", log_n, log_flit[0]); else passed++;
   endtask

   task automatic test_input_rr();
      bit e_r11 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      bit e_r10 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      int e_fl [4] = '{'h10, 'h11, 'h20, 'h21};
      dsel = 0;
      apply_reset();
      clear_stim();
      add_src(0, 1, 0, 'h10, 2);
      add_src(1, 1, 1, 'h20, 2);
      run(8);
      for (int c = 0; c < 4; c++) begin
         total++;
         if (rdy_log[c][1][1] !== e_r11[c] || rdy_log[c][1][0] !== e_r10[c])
            $display("FAIL rr_ready_c%0d: got in0=%b in1=%b want in0=%b in1=%b",
                     c, rdy_log[c][1][0], rdy_log[c][1][1], e_r10[c], e_r11[c]);
         else passed++;
      end
      total++; if (log_n !== 4) $display("FAIL rr_count: got %0d want 4", log_n); else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (log_vc[k] !== 7'b0000010 || log_flit[k] !== FW'(e_fl[k]) || log_last[k] !== (k % 2 == 1) || log_cyc[k] !== k + 1)
            $display("FAIL rr_flit%0d: got vc=%b flit=%h last=%b cyc=%0d want vc=0000010 flit=%h last=%0d cyc=%0d",
                     k, log_vc[k], log_flit[k], log_last[k], log_cyc[k], e_fl[k], k % 2 == 1, k + 1);
         else passed++;
      end
   endtask

   task automatic test_credit_stall();
      int e_fl [5] = '{'h30, 'h31, 'h32, 'h33, 'h34};
      int e_cy [5] = '{1, 2, 7, 11, 12};
      dsel = 1;
      apply_reset();
      clear_stim();
      add_src(0, 0, 0, 'h30, 6);
      $display("note: credit pulse on VC0 at full credit is a deliberate protocol violation and must be ignored");
      cred_sched[0][0] = 1'b1;
      cred_sched[6][0] = 1'b1;
      cred_sched[10][0] = 1'b1;
      cred_sched[11][0] = 1'b1;
      run(20);
      total++; if (log_n !== 5) $display("FAIL credit_count: got %0d want 5", log_n); else passed++;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (log_flit[k] !== FW'(e_fl[k]) || log_cyc[k] !== e_cy[k] || log_vc[k] !== 7'b0000001)
            $display("FAIL credit_flit%0d: got flit=%h cyc=%0d vc=%b want flit=%h cyc=%0d vc=0000001",
                     k, log_flit[k], log_cyc[k], log_vc[k], e_fl[k], e_cy[k]);
         else passed++;
      end
   endtask

   task automatic test_vc_mode();
      int e0_vc [6] = '{1, 1, 1, 4, 4, 4};
      int e0_fl [6] = '{'h40, 'h41, 'h42, 'h50, 'h51, 'h52};
      int e1_vc [6] = '{1, 4, 1, 4, 1, 4};
      int e1_fl [6] = '{'h40, 'h50, 'h41, 'h51, 'h42, 'h52};
      for (int m = 0; m < 2; m++) begin
         dsel = (m == 0) ? 0 : 2;
         apply_reset();
         clear_stim();
         add_src(0, 0, 0, 'h40, 3);
         add_src(1, 2, 3, 'h50, 3);
         run(10);
         total++; if (log_n !== 6) $display("FAIL mode%0d_count: got %0d want 6", m, log_n); else passed++;
         for (int k = 0; k < 6; k++) begin
            int ev, ef;
            ev = (m == 0) ? e0_vc[k] : e1_vc[k];
            ef = (m == 0) ? e0_fl[k] : e1_fl[k];
            total++;
            if (log_vc[k] !== 7'(ev) || log_flit[k] !== FW'(ef) || log_cyc[k] !== k + 1)
               $display("FAIL mode%0d_flit%0d: got vc=%b flit=%h cyc=%0d want vc=%b flit=%h cyc=%0d",
                        m, k, log_vc[k], log_flit[k], log_cyc[k], 7'(ev), ef, k + 1);
            else passed++;
         end
      end
   endtask

   task automatic test_full_fifo();
      bit e_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      dsel = 0;
      apply_reset();
      clear_stim();
      add_src(0, 3, 0, 'h60, 4);
      run(8);
      total++; if (log_n !== 4) $display("FAIL full_drain_count: got %0d want 4", log_n); else passed++;
      clear_stim();
      add_src(0, 3, 0, 'h70, 6);
      cred_sched[5][3] = 1'b1;
      cred_sched[6][3] = 1'b1;
      run(14);
      for (int c = 3; c < 8; c++) begin
         total++;
         if (rdy_log[c][3][0] !== e_rdy[c - 3])
            $display("FAIL full_ready_c%0d: got %b want %b", c, rdy_log[c][3][0], e_rdy[c - 3]);
         else passed++;
      end
      total++; if (acc_cyc[0][4] !== 6 || acc_cyc[0][5] !== 7)
         $display("FAIL full_push_pop: got acc4=%0d acc5=%0d want 6 7", acc_cyc[0][4], acc_cyc[0][5]); else passed++;
      total++;
      if (log_n !== 2 || log_flit[0] !== FW'('h70) || log_cyc[0] !== 6 || log_flit[1] !== FW'('h71) || log_cyc[1] !== 7)
         $display("FAIL full_sends: got n=%0d %h@%0d %h@%0d want n=2 70@6 71@7",
                  log_n, log_flit[0], log_cyc[0], log_flit[1], log_cyc[1]);
      else passed++;
   endtask

   task automatic test_reset_mid_packet();
      dsel = 0;
      apply_reset();
      clear_stim();
      add_src(0, 4, 1, 'h80, 4);
      run(3);
      total++; if (log_n !== 2) $display("FAIL midrst_before: got %0d sent want 2", log_n); else passed++;
      rst = 1'b0;
      in_valid = '0;
      @(posedge clk);
      #1;
      total++; if (val_a !== '0 || rdy_a !== '0)
         $display("FAIL midrst_outputs: got valid=%b ready=%h want 0", val_a, rdy_a); else passed++;
      rst = 1'b1;
      clear_stim();
      run(10);
      total++; if (log_n !== 0) $display("FAIL midrst_stale: got %0d flits want 0", log_n); else passed++;
      clear_stim();
      add_src(0, 4, 1, 'h90, 4);
      run(10);
      total++; if (log_n !== 4 || log_flit[3] !== FW'('h93) || log_last[3] !== 1'b1 || log_cyc[3] !== 4)
         $display("FAIL midrst_credits: got n=%0d last_flit=%h last=%b cyc=%0d want n=4 93 1 4",
                  log_n, log_flit[3], log_last[3], log_cyc[3]);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total = 0;
      dsel = 0;
      rst = 1'b0;
      in_valid = '0; in_flit = '0; in_last = '0; out_credit = '0;
      clear_stim();
      test_reset();
      test_single_packet();
      test_input_rr();
      test_credit_stall();
      test_vc_mode();
      test_full_fifo();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
